sd_init_ctrl: RTL and testbench
===============================

SD_INIT_CTRL -- requirements
Module: sd_init_ctrl

Interface
REQ-001 SHALL have parameter POWERUP_CLKS, default 80: sd_clk cycles with sd_cs=1 and sd_mosi=1 before CMD0.
REQ-002 SHALL have parameter NCR_MAX, default 16: cycles allowed from command end to response start bit.
REQ-003 SHALL have parameter CMD0_RETRY, default 8: maximum CMD0 attempts.
REQ-004 SHALL have parameter ACMD41_RETRY, default 4095: maximum CMD55/ACMD41 pairs.
REQ-005 SHALL have port sd_clk  in  1: sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port start  in  1: one-cycle pulse; begins initialisation from IDLE, DONE or ERROR.
REQ-008 SHALL have port sd_miso  in  1: card serial data out.
REQ-009 SHALL have port sd_cs  out  1: card chip select, active low.
REQ-010 SHALL have port sd_mosi  out  1: card serial data in, MSB first.
REQ-011 SHALL have port init_done  out  1: level; card initialised.
REQ-012 SHALL have port init_err  out  1: level; initialisation failed.
REQ-013 SHALL have port err_code  out  3: 1 = CMD0 retries exhausted; 2 = CMD8 bad echo; 3 = ACMD41 retries exhausted; 4 = response timeout; 0 = no error.
REQ-014 SHALL have port last_resp  out  40: most recent response, right-aligned (R1 in [7:0]).

Function
REQ-015 SHALL implement states IDLE, POWERUP, SEND, WAIT_RESP, RECV, GAP, CHECK, DONE, ERROR.
REQ-016 IDLE: sd_cs=1, sd_mosi=1; start -> POWERUP and clear init_done, init_err and err_code.
REQ-017 POWERUP SHALL last exactly POWERUP_CLKS cycles, then -> SEND with CMD0.
REQ-018 SEND SHALL hold sd_cs=0 and shift the 48-bit frame, 1 bit/cycle, bit 47 on the first SEND cycle; exactly 48 cycles; then -> WAIT_RESP.
REQ-019 WAIT_RESP SHALL hold sd_mosi=1 and sd_cs=0; the first sampled sd_miso=0 is response bit 7 -> RECV; after NCR_MAX cycles without a 0 -> ERROR, err_code=4.
REQ-020 RECV SHALL capture 8 bits for CMD0/CMD55/ACMD41 and 40 bits for CMD8, including the start bit, MSB first.
REQ-021 GAP SHALL drive sd_cs=1 and sd_mosi=1 for 8 cycles, then -> CHECK.
REQ-022 CHECK after CMD0: R1=0x01 -> CMD8; otherwise retry CMD0; on the CMD0_RETRY-th failure -> ERROR, err_code=1.
REQ-023 CHECK after CMD8: R1=0x01 and bits[11:0]=0x1AA -> CMD55; otherwise -> ERROR, err_code=2.
REQ-024 CHECK after CMD55: R1 bit7=0 -> ACMD41 (the R1 value is not otherwise checked).
REQ-025 CHECK after ACMD41: R1=0x00 -> DONE; R1=0x01 -> CMD55 with the pair count incremented; on the ACMD41_RETRY-th pair, or any other R1 -> ERROR, err_code=3.
REQ-026 DONE: init_done=1, sd_cs=1, sd_mosi=1; hold until start or rst.
REQ-027 ERROR: init_err=1, sd_cs=1; hold until start or rst.
REQ-028 start SHALL be ignored in all states except IDLE, DONE and ERROR.
REQ-029 last_resp SHALL update on the last RECV cycle, zero-extended for R1.
REQ-030 Retry counters SHALL saturate and never wrap; the ACMD41 counter is 12 bits.

Reset
REQ-031 rst SHALL take priority over start in any state, mid-frame included.
REQ-032 On rst the block SHALL enter IDLE with sd_cs=1, sd_mosi=1, init_done=0, init_err=0, err_code=0, last_resp=0 and all counters 0.

Structure
REQ-033 The CMD0, CMD8, CMD55 and ACMD41 48-bit frames, the state encoding and the err_code values SHALL reside in a shared package, sd_pkg.
REQ-034 Response capture (WAIT_RESP/RECV shift register, length select, timeout) SHALL be a sub-module sd_resp_rx.

Verification
REQ-035 Card model replies CMD0 0x01, CMD8 0x01_000001AA, CMD55 0x01, ACMD41 0x01 twice then 0x00; start -> init_done=1 with exactly 3 CMD55/ACMD41 pairs and last_resp=0x00.
REQ-036 sd_miso held at 1 -> after CMD0, init_err=1 and err_code=4 exactly NCR_MAX cycles after the CMD0 frame ends.
REQ-037 CMD0 always replies 0x05 -> 8 CMD0 frames, then err_code=1.
REQ-038 CMD8 echoes 0x0AB -> err_code=2, and no CMD55 is issued.
REQ-039 rst asserted at bit 20 of the CMD8 frame -> next cycle IDLE with sd_cs=1; a following start restarts with POWERUP of 80 cycles.
REQ-040 Bit check: the first 48 sd_mosi bits after POWERUP equal 0x400000000095, with sd_cs=0 throughout the frame.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI initialisation controller:
// FSM encoding, command frames, error codes and response-capture status.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECV,
    ST_GAP,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    CMD_GO_IDLE,   // CMD0
    CMD_IF_COND,   // CMD8
    CMD_APP,       // CMD55
    CMD_SD_OP      // ACMD41
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD0    = 3'd1,
    ERR_CMD8    = 3'd2,
    ERR_ACMD41  = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  // Start bit seen, wait timed out, last response bit being sampled.
  typedef struct packed {
    logic start;
    logic timeout;
    logic last;
  } rx_stat_t;

  localparam int FRAME_BITS = 48;
  localparam int R1_BITS    = 8;
  localparam int R7_BITS    = 40;
  localparam int GAP_CLKS   = 8;

  // Full frames including start/transmission bits and CRC7 + end bit.
  localparam logic [47:0] FRAME_CMD0   = 48'h40_0000_0000_95;
  localparam logic [47:0] FRAME_CMD8   = 48'h48_0000_01AA_87;
  localparam logic [47:0] FRAME_CMD55  = 48'h77_0000_0000_65;
  localparam logic [47:0] FRAME_ACMD41 = 48'h69_4000_0000_77;

  function automatic logic [47:0] cmd_frame(input cmd_e c);
    logic [47:0] f;
    case (c)
      CMD_GO_IDLE: f = FRAME_CMD0;
      CMD_IF_COND: f = FRAME_CMD8;
      CMD_APP:     f = FRAME_CMD55;
      default:     f = FRAME_ACMD41;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sd_resp_rx.sv
// Response capture: hunts for the start bit within NCR_MAX cycles, then
// shifts in an 8-bit R1 or a 40-bit R7, MSB first.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wait_en,
  input  logic        recv_en,
  input  logic        long_resp,
  input  logic        miso,
  output rx_stat_t    stat,
  output logic [39:0] resp
);

  localparam int CNT_MAX = (NCR_MAX > R7_BITS) ? NCR_MAX : R7_BITS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d, len_m1;
  logic [39:0]   shift_q, shift_d;

  assign len_m1 = long_resp ? CW'(R7_BITS - 1) : CW'(R1_BITS - 1);

  always_comb begin
    cnt_d   = '0;
    shift_d = shift_q;
    stat    = '0;
    // The final bit is still on miso during the last cycle, so fold it in here.
    resp    = long_resp ? {shift_q[38:0], miso} : {32'b0, shift_q[6:0], miso};
    if (wait_en) begin
      if (!miso) begin
        stat.start = 1'b1;
        shift_d    = '0;
        cnt_d      = CW'(1);
      end else begin
        stat.timeout = (cnt_q == CW'(NCR_MAX - 1));
        cnt_d        = cnt_q + 1'b1;
      end
    end else if (recv_en) begin
      shift_d = {shift_q[38:0], miso};
      if (cnt_q == len_m1) stat.last = 1'b1;
      else                 cnt_d     = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/sd_init_ctrl.sv
// SD-card SPI-mode initialisation sequencer: power-up clocks, CMD0, CMD8,
// then CMD55/ACMD41 pairs until the card leaves idle, with retry/timeout.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int POWERUP_CLKS = 80,
  parameter int NCR_MAX      = 16,
  parameter int CMD0_RETRY   = 8,
  parameter int ACMD41_RETRY = 4095
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sd_miso,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [39:0] last_resp
);

  localparam int TMAX = (POWERUP_CLKS > FRAME_BITS) ? POWERUP_CLKS : FRAME_BITS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int C0W  = $clog2(CMD0_RETRY + 1);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  err_e          code_q, code_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [C0W-1:0] cmd0_cnt_q, cmd0_cnt_d;
  logic [11:0]   acmd_cnt_q, acmd_cnt_d;
  logic          done_q, done_d, err_q, err_d;
  logic [39:0]   resp_q, resp_d;

  rx_stat_t      rx_stat;
  logic [39:0]   rx_resp;
  logic [47:0]   frame;
  logic [5:0]    bit_idx;
  logic [7:0]    r1;

  sd_resp_rx #(.NCR_MAX(NCR_MAX)) u_rx (
    .clk       (sd_clk),
    .rst       (rst),
    .wait_en   (state_q == ST_WAIT_RESP),
    .recv_en   (state_q == ST_RECV),
    .long_resp (cmd_q == CMD_IF_COND),
    .miso      (sd_miso),
    .stat      (rx_stat),
    .resp      (rx_resp)
  );

  assign frame   = cmd_frame(cmd_q);
  assign bit_idx = 6'(FRAME_BITS - 1) - tick_q[5:0];
  assign r1      = resp_q[7:0];

  assign sd_cs     = !(state_q inside {ST_SEND, ST_WAIT_RESP, ST_RECV});
  assign sd_mosi   = (state_q == ST_SEND) ? frame[bit_idx] : 1'b1;
  assign init_done = done_q;
  assign init_err  = err_q;
  assign err_code  = code_q;
  assign last_resp = resp_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    code_d     = code_q;
    tick_d     = tick_q;
    cmd0_cnt_d = cmd0_cnt_q;
    acmd_cnt_d = acmd_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    resp_d     = resp_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_POWERUP;
          cmd_d      = CMD_GO_IDLE;
          tick_d     = '0;
          cmd0_cnt_d = '0;
          acmd_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          code_d     = ERR_NONE;
        end
      end
      ST_POWERUP: begin
        if (tick_q == TW'(POWERUP_CLKS - 1)) begin
          state_d = ST_SEND;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (tick_q == TW'(FRAME_BITS - 1)) begin
          state_d = ST_WAIT_RESP;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (rx_stat.start) begin
          state_d = ST_RECV;
        end else if (rx_stat.timeout) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      ST_RECV: begin
        if (rx_stat.last) begin
          state_d = ST_GAP;
          resp_d  = rx_resp;
          tick_d  = '0;
        end
      end
      ST_GAP: begin
        if (tick_q == TW'(GAP_CLKS - 1)) state_d = ST_CHECK;
        else                            tick_d  = tick_q + 1'b1;
      end
      ST_CHECK: begin
        // Every non-terminal outcome sends another frame.
        state_d = ST_SEND;
        tick_d  = '0;
        case (cmd_q)
          CMD_GO_IDLE: begin
            if (r1 == 8'h01) begin
              cmd_d = CMD_IF_COND;
            end else begin
              cmd0_cnt_d = (&cmd0_cnt_q) ? cmd0_cnt_q : cmd0_cnt_q + 1'b1;
              if (int'(cmd0_cnt_q) + 1 >= CMD0_RETRY) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
                code_d  = ERR_CMD0;
              end
            end
          end
          CMD_IF_COND: begin
            if (resp_q[39:32] == 8'h01 && resp_q[11:0] == 12'h1AA) begin
              cmd_d = CMD_APP;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
              code_d  = ERR_CMD8;
            end
          end
          CMD_APP: begin
            if (!r1[7]) begin
              cmd_d = CMD_SD_OP;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
              code_d  = ERR_ACMD41;
            end
          end
          default: begin
            if (r1 == 8'h00) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if (r1 == 8'h01 && int'(acmd_cnt_q) + 1 < ACMD41_RETRY) begin
              cmd_d      = CMD_APP;
              acmd_cnt_d = (&acmd_cnt_q) ? acmd_cnt_q : acmd_cnt_q + 1'b1;
            end else begin
              acmd_cnt_d = (&acmd_cnt_q) ? acmd_cnt_q : acmd_cnt_q + 1'b1;
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              code_d     = ERR_ACMD41;
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_GO_IDLE;
      code_q     <= ERR_NONE;
      tick_q     <= '0;
      cmd0_cnt_q <= '0;
      acmd_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      code_q     <= code_d;
      tick_q     <= tick_d;
      cmd0_cnt_q <= cmd0_cnt_d;
      acmd_cnt_q <= acmd_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      resp_q     <= resp_d;
    end
  end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: behavioural SPI card plus a scenario table and
// directed sequences for timeout timing and mid-frame reset.
module tb_sd_init_ctrl;

  localparam int NCR   = 16;
  localparam int PWRUP = 80;

  logic        sd_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        sd_miso = 1'b1;
  logic        sd_cs, sd_mosi, init_done, init_err;
  logic [2:0]  err_code;
  logic [39:0] last_resp;

  int checks = 0;
  int errors = 0;

  always #5 sd_clk = ~sd_clk;

  sd_init_ctrl #(
    .POWERUP_CLKS (PWRUP),
    .NCR_MAX      (NCR),
    .CMD0_RETRY   (8),
    .ACMD41_RETRY (5)
  ) dut (
    .sd_clk    (sd_clk),
    .rst       (rst),
    .start     (start),
    .sd_miso   (sd_miso),
    .sd_cs     (sd_cs),
    .sd_mosi   (sd_mosi),
    .init_done (init_done),
    .init_err  (init_err),
    .err_code  (err_code),
    .last_resp (last_resp)
  );

  // Card configuration (written by the test, read by the card model)
  int          cfg_cmd0_bad   = 0;
  logic [39:0] cfg_cmd8_resp  = 40'h01_0000_01AA;
  int          cfg_acmd_busy  = 0;
  logic [7:0]  cfg_acmd_final = 8'h00;
  bit          cfg_silent     = 1'b0;
  bit          card_clr       = 1'b0;

  // Card state
  int          n_cmd0, n_cmd8, n_cmd55, n_acmd, n_frames;
  logic [47:0] first_frame;
  logic [47:0] rx_sh = '0;
  int          rx_n = 0;
  bit          rx_busy = 1'b0;
  bit          rq[$];

  task automatic push8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) rq.push_back(b[i]);
  endtask

  task automatic card_reply(input logic [47:0] f);
    logic [5:0] idx;
    idx = f[45:40];
    n_frames++;
    if (n_frames == 1) first_frame = f;
    if (cfg_silent) return;
    rq.push_back(1'b1);
    case (idx)
      6'd0: begin
        n_cmd0++;
        push8((n_cmd0 <= cfg_cmd0_bad) ? 8'h05 : 8'h01);
      end
      6'd8: begin
        n_cmd8++;
        for (int i = 39; i >= 0; i--) rq.push_back(cfg_cmd8_resp[i]);
      end
      6'd55: begin
        n_cmd55++;
        push8(8'h01);
      end
      6'd41: begin
        n_acmd++;
        push8((n_acmd <= cfg_acmd_busy) ? 8'h01 : cfg_acmd_final);
      end
      default: ;
    endcase
  endtask

  always @(negedge sd_clk) begin
    if (card_clr) begin
      n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0; n_acmd = 0; n_frames = 0;
      first_frame = '0;
    end
    if (sd_cs) begin
      rx_n = 0;
      rx_busy = 1'b0;
      rq.delete();
      sd_miso = 1'b1;
    end else begin
      if (rq.size() > 0) sd_miso = rq.pop_front();
      else               sd_miso = 1'b1;
      if (!rx_busy) begin
        rx_sh = {rx_sh[46:0], sd_mosi};
        rx_n++;
        if (rx_n == 48) begin
          rx_busy = 1'b1;
          card_reply(rx_sh);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cs(input logic val, input string nm);
    int n;
    n = 0;
    while (sd_cs !== val && n < 3000) begin
      @(negedge sd_clk);
      n++;
    end
    if (sd_cs !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: sd_cs never reached %0b", nm, val);
    end
  endtask

  // Pulse start, then count POWERUP cycles (sd_cs high) until the first frame.
  task automatic start_and_measure(input string nm, input bit poke_mid);
    int n;
    start = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    n = 0;
    while (sd_cs && n < 1000) begin
      n++;
      start = (poke_mid && n == 40);
      @(negedge sd_clk);
    end
    start = 1'b0;
    chk(nm, n, PWRUP);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    card_clr = 1'b1;
    @(negedge sd_clk);
    @(negedge sd_clk);
    rst = 1'b0;
    card_clr = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          cmd0_bad;
    logic [39:0] cmd8_resp;
    int          acmd_busy;
    logic [7:0]  acmd_final;
    bit          silent;
    bit          exp_done;
    bit          exp_err;
    logic [2:0]  exp_code;
    logic [39:0] exp_last;
    int          exp_cmd0;
    int          exp_cmd55;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [47:0] f8;
    int n;
    f8 = 48'h48_0000_01AA_87;

    vecs[0] = '{"normal",      0,   40'h01_0000_01AA, 2,   8'h00, 0, 1, 0, 3'd0, 40'h00,          1, 3};
    vecs[1] = '{"cmd0_fail",   100, 40'h01_0000_01AA, 2,   8'h00, 0, 0, 1, 3'd1, 40'h05,          8, 0};
    vecs[2] = '{"cmd0_7bad",   7,   40'h01_0000_01AA, 2,   8'h00, 0, 1, 0, 3'd0, 40'h00,          8, 3};
    vecs[3] = '{"cmd8_echo",   0,   40'h01_0000_00AB, 2,   8'h00, 0, 0, 1, 3'd2, 40'h01_0000_00AB, 1, 0};
    vecs[4] = '{"cmd8_r1",     0,   40'h05_0000_01AA, 2,   8'h00, 0, 0, 1, 3'd2, 40'h05_0000_01AA, 1, 0};
    vecs[5] = '{"silent",      0,   40'h01_0000_01AA, 2,   8'h00, 1, 0, 1, 3'd4, 40'h00,          0, 0};
    vecs[6] = '{"acmd_exhaust",0,   40'h01_0000_01AA, 100, 8'h00, 0, 0, 1, 3'd3, 40'h01,          1, 5};
    vecs[7] = '{"acmd_lastok", 0,   40'h01_0000_01AA, 4,   8'h00, 0, 1, 0, 3'd0, 40'h00,          1, 5};
    vecs[8] = '{"acmd_bad",    0,   40'h01_0000_01AA, 1,   8'h05, 0, 0, 1, 3'd3, 40'h05,          1, 2};
    vecs[9] = '{"acmd_fast",   0,   40'h01_0000_01AA, 0,   8'h00, 0, 1, 0, 3'd0, 40'h00,          1, 1};

    // Reset state
    do_reset();
    chk("rst_cs",   sd_cs, 1);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_done", init_done, 0);
    chk("rst_err",  init_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_resp", last_resp, 0);

    // Scenario table
    for (int v = 0; v < 10; v++) begin
      cfg_cmd0_bad   = vecs[v].cmd0_bad;
      cfg_cmd8_resp  = vecs[v].cmd8_resp;
      cfg_acmd_busy  = vecs[v].acmd_busy;
      cfg_acmd_final = vecs[v].acmd_final;
      cfg_silent     = vecs[v].silent;
      do_reset();
      start_and_measure({vecs[v].name, "_powerup"}, 1'b0);
      n = 0;
      while (!(init_done || init_err) && n < 5000) begin
        @(negedge sd_clk);
        n++;
      end
      repeat (2) @(negedge sd_clk);
      chk({vecs[v].name, "_frame0"}, first_frame, 48'h40_0000_0000_95);
      chk({vecs[v].name, "_done"},  init_done, vecs[v].exp_done);
      chk({vecs[v].name, "_err"},   init_err,  vecs[v].exp_err);
      chk({vecs[v].name, "_code"},  err_code,  vecs[v].exp_code);
      chk({vecs[v].name, "_resp"},  last_resp, vecs[v].exp_last);
      chk({vecs[v].name, "_ncmd0"}, n_cmd0,    vecs[v].exp_cmd0);
      chk({vecs[v].name, "_ncmd55"}, n_cmd55,  vecs[v].exp_cmd55);
      chk({vecs[v].name, "_cs_idle"}, sd_cs, 1);
    end

    // Response timeout lands exactly NCR cycles after the CMD0 frame
    cfg_silent = 1'b1;
    do_reset();
    start = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    wait_cs(1'b0, "to_frame_start");
    repeat (48 + NCR - 1) @(negedge sd_clk);
    chk("to_before", init_err, 0);
    chk("to_cs_low", sd_cs, 0);
    @(negedge sd_clk);
    chk("to_exact", init_err, 1);
    chk("to_code",  err_code, 4);
    cfg_silent = 1'b0;

    // Reset during bit 20 of the CMD8 frame, then restart
    cfg_cmd0_bad  = 0;
    cfg_cmd8_resp = 40'h01_0000_01AA;
    cfg_acmd_busy = 2;
    cfg_acmd_final = 8'h00;
    do_reset();
    start = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    n = 0;
    while (n_frames < 1 && n < 3000) begin
      @(negedge sd_clk);
      n++;
    end
    wait_cs(1'b1, "mid_gap");
    wait_cs(1'b0, "mid_cmd8_start");
    repeat (27) @(negedge sd_clk);
    chk("mid_bit20", sd_mosi, f8[20]);
    rst = 1'b1;
    card_clr = 1'b1;
    @(negedge sd_clk);
    chk("mid_rst_cs",   sd_cs, 1);
    chk("mid_rst_mosi", sd_mosi, 1);
    chk("mid_rst_resp", last_resp, 0);
    rst = 1'b0;
    card_clr = 1'b0;
    @(negedge sd_clk);
    chk("mid_idle_cs", sd_cs, 1);
    start_and_measure("mid_restart_powerup", 1'b1);
    n = 0;
    while (!(init_done || init_err) && n < 5000) begin
      @(negedge sd_clk);
      n++;
    end
    chk("mid_restart_done", init_done, 1);
    chk("mid_restart_ncmd55", n_cmd55, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
